axis_skid_slice: RTL and testbench

Full-throughput AXI-Stream register slice with a two-entry skid buffer, parametrised in data and sideband width, with a completed-packet counter. It breaks every combinational path between its slave and master sides, including tvalid/tdata forward and tready backward, while sustaining one beat per cycle. It is inserted between stream stages wherever timing closure needs a full pipeline cut without losing bandwidth.

---
 rtl/axis_skid_slice.sv | 152 +++++++++++++++
 tb/tb_axis_skid_slice.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_skid_slice.sv
// AXI-Stream register slice with a two-entry skid buffer: every output, including
// s_tready, comes straight from a flop while sustaining one beat per cycle.
module axis_skid_slice #(
  parameter int DW    = 8,
  parameter int UW    = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    s_tdata,
  input  logic [UW-1:0]    s_tuser,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [DW-1:0]    m_tdata,
  output logic [UW-1:0]    m_tuser,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] pkt_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [DW-1:0]    main_data_r, skid_data_r;
  logic [UW-1:0]    main_user_r, skid_user_r;
  logic             main_last_r, skid_last_r;
  logic             main_valid_r;
  logic             s_tready_r;
  logic [1:0]       occupancy_r, occupancy_s;
  logic [CNT_W-1:0] pkt_cnt_r;
  logic             acc_s, pop_s;
  logic             ld_in_s, ld_skid_s, mv_skid_s;

  assign acc_s = s_tvalid & s_tready_r;
  assign pop_s = main_valid_r & m_tready;

  // Next state and datapath load selects.
  always_comb begin
    state_s   = state_r;
    ld_in_s   = 1'b0;
    ld_skid_s = 1'b0;
    mv_skid_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (acc_s) begin
          ld_in_s = 1'b1;
          state_s = ONE;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (acc_s && !pop_s) begin
          ld_skid_s = 1'b1;
          state_s   = FULL;
        end else if (acc_s && pop_s) begin
          ld_in_s = 1'b1;
          state_s = ONE;
        end else if (pop_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        // s_tready is low here, so only a pop can move us.
        if (pop_s) begin
          mv_skid_s = 1'b1;
          state_s   = ONE;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // Occupancy that the next state implies.
  always_comb begin
    occupancy_s = 2'd0;
    case (state_s)
      EMPTY:   occupancy_s = 2'd0;
      ONE:     occupancy_s = 2'd1;
      FULL:    occupancy_s = 2'd2;
      default: occupancy_s = 2'd0;
    endcase
  end

  // State, status flags and packet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= EMPTY;
      main_valid_r <= 1'b0;
      s_tready_r   <= 1'b0;
      occupancy_r  <= 2'd0;
      pkt_cnt_r    <= '0;
    end else begin
      state_r      <= state_s;
      main_valid_r <= (state_s != EMPTY);
      s_tready_r   <= (state_s != FULL);
      occupancy_r  <= occupancy_s;
      if (pop_s && main_last_r) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
      end
    end
  end

  // Main and skid payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_r <= '0;
      main_user_r <= '0;
      main_last_r <= 1'b0;
      skid_data_r <= '0;
      skid_user_r <= '0;
      skid_last_r <= 1'b0;
    end else begin
      if (ld_in_s) begin
        main_data_r <= s_tdata;
        main_user_r <= s_tuser;
        main_last_r <= s_tlast;
      end else if (mv_skid_s) begin
        main_data_r <= skid_data_r;
        main_user_r <= skid_user_r;
        main_last_r <= skid_last_r;
      end
      if (ld_skid_s) begin
        skid_data_r <= s_tdata;
        skid_user_r <= s_tuser;
        skid_last_r <= s_tlast;
      end
    end
  end

  assign s_tready  = s_tready_r;
  assign m_tdata   = main_data_r;
  assign m_tuser   = main_user_r;
  assign m_tlast   = main_last_r;
  assign m_tvalid  = main_valid_r;
  assign occupancy = occupancy_r;
  assign pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_axis_skid_slice.sv
// Directed and randomised checks of axis_skid_slice with a small in-order scoreboard.
module tb_axis_skid_slice;

  localparam int DW    = 8;
  localparam int UW    = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    s_tdata;
  logic [UW-1:0]    s_tuser;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [DW-1:0]    m_tdata;
  logic [UW-1:0]    m_tuser;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  axis_skid_slice #(.DW(DW), .UW(UW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .occupancy(occupancy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [12:0] q[$];
  logic [12:0] front;
  logic [1:0]  wrap_exp [5];
  logic [1:0]  cnt_model;
  int          sent;
  int          cycles;
  logic        acc;
  logic        pop;
  logic        ovf;

  initial begin
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1; s_tdata = 8'h00; s_tuser = 4'h0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    step(); step();
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_ready", 32'(s_tready), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_data", 32'(m_tdata), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(s_tready), 32'd1);

    // 1: streaming
    m_tready = 1'b1; s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tdata = 8'(i); s_tuser = 4'(i); s_tlast = (i == 7) || (i == 15);
      step();
      chk("stream_valid", 32'(m_tvalid), 32'd1);
      chk("stream_data", 32'(m_tdata), 32'(i));
      chk("stream_user", 32'(m_tuser), 32'(i & 15));
      chk("stream_last", 32'(m_tlast), 32'((i == 7) || (i == 15)));
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_ready", 32'(s_tready), 32'd1);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    step();
    chk("stream_drain_valid", 32'(m_tvalid), 32'd0);
    chk("stream_drain_occ", 32'(occupancy), 32'd0);
    chk("stream_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // 2: skid fill
    s_tvalid = 1'b1; s_tdata = 8'hA0; s_tuser = 4'h0;
    step();
    chk("skid_a0", 32'(m_tdata), 32'hA0);
    s_tdata = 8'hA1; s_tuser = 4'h1; m_tready = 1'b0;
    step();
    chk("skid_occ2", 32'(occupancy), 32'd2);
    chk("skid_ready0", 32'(s_tready), 32'd0);
    chk("skid_hold_a0", 32'(m_tdata), 32'hA0);
    s_tdata = 8'hA2; s_tuser = 4'h2;
    step();
    step();
    chk("skid_still_occ2", 32'(occupancy), 32'd2);
    chk("skid_still_a0", 32'(m_tdata), 32'hA0);
    chk("skid_still_user0", 32'(m_tuser), 32'h0);
    chk("skid_still_ready0", 32'(s_tready), 32'd0);
    m_tready = 1'b1;
    step();
    chk("skid_rel_a1", 32'(m_tdata), 32'hA1);
    chk("skid_rel_user1", 32'(m_tuser), 32'h1);
    chk("skid_rel_ready", 32'(s_tready), 32'd1);
    chk("skid_rel_occ", 32'(occupancy), 32'd1);
    step();
    chk("skid_a2", 32'(m_tdata), 32'hA2);
    chk("skid_a2_user", 32'(m_tuser), 32'h2);
    s_tvalid = 1'b0;
    step();
    chk("skid_empty", 32'(m_tvalid), 32'd0);
    chk("skid_cnt_same", 32'(pkt_cnt), 32'd2);

    // 6: stalled source, one copy only
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hB0;
    step();
    s_tdata = 8'hB1;
    step();
    s_tdata = 8'h55;
    step(); step();
    chk("stall_occ2", 32'(occupancy), 32'd2);
    chk("stall_b0", 32'(m_tdata), 32'hB0);
    m_tready = 1'b1;
    step();
    chk("stall_b1", 32'(m_tdata), 32'hB1);
    step();
    chk("stall_55", 32'(m_tdata), 32'h55);
    s_tvalid = 1'b0;
    step();
    chk("stall_single_copy", 32'(m_tvalid), 32'd0);

    // 5: reset mid-stream from FULL
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hC0; s_tuser = 4'h9; s_tlast = 1'b1;
    step();
    s_tdata = 8'hC1;
    step();
    chk("pre_rst_occ2", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_mvalid", 32'(m_tvalid), 32'd0);
    chk("arst_mdata", 32'(m_tdata), 32'd0);
    chk("arst_muser", 32'(m_tuser), 32'd0);
    chk("arst_mlast", 32'(m_tlast), 32'd0);
    chk("arst_ready", 32'(s_tready), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_cnt", 32'(pkt_cnt), 32'd0);
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(s_tready), 32'd1);
    chk("post_rst_mvalid", 32'(m_tvalid), 32'd0);
    step();
    chk("post_rst_no_stale", 32'(m_tvalid), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);

    // 4: counter wrap with five single-beat packets
    for (int k = 0; k < 5; k++) begin
      s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 8'(k);
      step();
      s_tvalid = 1'b0;
      step();
      chk("wrap_cnt", 32'(pkt_cnt), 32'(wrap_exp[k]));
    end
    s_tlast = 1'b0;

    // 3: random valid/ready scoreboard
    cnt_model = 2'd1;
    sent = 0;
    cycles = 0;
    while ((sent < 1000 || q.size() != 0) && cycles < 20000) begin
      s_tvalid = (sent < 1000) && ($urandom_range(1) == 1);
      s_tdata  = 8'($urandom);
      s_tuser  = 4'(sent);
      s_tlast  = 1'($urandom);
      m_tready = 1'($urandom);
      acc = s_tvalid & s_tready;
      pop = m_tvalid & m_tready;
      if (pop) begin
        if (q.size() == 0) begin
          chk("rand_pop_empty", 32'(m_tvalid), 32'd0);
        end else begin
          front = q.pop_front();
          chk("rand_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(front));
          if (front[0]) cnt_model = cnt_model + 2'd1;
        end
      end
      if (acc) begin
        q.push_back({s_tdata, s_tuser, s_tlast});
        sent++;
      end
      step();
      ovf = (q.size() > 2);
      chk("rand_occ", 32'(occupancy), 32'(q.size()));
      chk("rand_ready", 32'(s_tready), 32'(!ovf && q.size() < 2));
      cycles++;
    end
    chk("rand_done_in_budget", 32'(q.size()), 32'd0);
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_pkt_cnt", 32'(pkt_cnt), 32'(cnt_model));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
